// File: rtl/ctrl_pkg.sv
// Shared state, opcode/funct and datapath-select encodings for the multicycle controller.
package ctrl_pkg;

    typedef enum logic [4:0] {
        RST, FETCH, IR_LOAD, DECODE,
        R_EX, R_WB, ADDI_EX, ADDI_WB,
        MEM_ADDR, LW_WAIT, LW_MDR, LW_WB, SW,
        BRANCH, JUMP,
        EXC_OVF, EXC_OPC, EXC_RD, EXC_JMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_SRST  = 6'd63;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    localparam logic [1:0] SRCA_PC = 2'd0;
    localparam logic [1:0] SRCA_A  = 2'd1;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_EXC    = 3'd3;

    localparam logic [2:0] ADDR_PC     = 3'd0;
    localparam logic [2:0] ADDR_ALUOUT = 3'd1;
    localparam logic [2:0] ADDR_OPC    = 3'd2;
    localparam logic [2:0] ADDR_OVF    = 3'd3;

    localparam logic [1:0] RW_RT = 2'd0;
    localparam logic [1:0] RW_RD = 2'd1;
    localparam logic [1:0] RW_RA = 2'd2;
    localparam logic [1:0] RW_SP = 2'd3;

    localparam logic [3:0] WD_ALUOUT = 4'd0;
    localparam logic [3:0] WD_MDR    = 4'd1;
    localparam logic [3:0] WD_SP     = 4'd10;

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter: counts up while enabled, saturating at MEM_WAIT-1 where done is high.
// Latency: done is combinational from the count; clear has priority over enable.
// Backpressure: none; the FSM clears it on every state change.
module ctrl_wait_cnt #(
    parameter int MEM_WAIT = 3,
    parameter int CW       = $clog2(MEM_WAIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [CW-1:0] cnt;

    assign done = (cnt == CW'(MEM_WAIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with memory wait states and precise exceptions.
// Latency: Moore outputs from the state register; only BRANCH PCWrite follows the ALU flags.
// Backpressure: none; memory reads are covered by a fixed MEM_WAIT cycle count.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 3,
    parameter int RESET_SP = 227,
    parameter int CW       = $clog2(MEM_WAIT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       O,
    input  logic       LT,
    input  logic       GT,
    input  logic [5:0] OPCODE,
    input  logic [5:0] funct,
    output logic       PCWrite,
    output logic       MemWR,
    output logic       IRWrite,
    output logic       ABWrite,
    output logic       MDRWrite,
    output logic       ALUOut_w,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] RegWriteMUX,
    output logic [2:0] MuxAddr,
    output logic [2:0] ALUControl,
    output logic [2:0] PCSrc,
    output logic [3:0] WriteDataCtrl,
    output logic       rst_out
);

    if (MEM_WAIT < 1 || MEM_WAIT > 15 || RESET_SP < 0) begin : g_bad_param
        $error("multicycle_ctrl: MEM_WAIT must be 1..15 and RESET_SP non-negative");
    end

    state_t state_q, state_d;
    logic   cause_ovf_q;
    logic   wait_done;
    logic   equal;

    assign equal = !LT && !GT;

    ctrl_wait_cnt #(
        .MEM_WAIT (MEM_WAIT),
        .CW       (CW)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_d != state_q),
        .en    (state_q == FETCH || state_q == LW_WAIT || state_q == EXC_RD),
        .done  (wait_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RST;
            cause_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == EXC_OVF) begin
                cause_ovf_q <= 1'b1;
            end else if (state_q == EXC_OPC) begin
                cause_ovf_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        MemWR         = 1'b0;
        IRWrite       = 1'b0;
        ABWrite       = 1'b0;
        MDRWrite      = 1'b0;
        ALUOut_w      = 1'b0;
        RegWrite      = 1'b0;
        EPCWrite      = 1'b0;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_B;
        RegWriteMUX   = RW_RT;
        MuxAddr       = ADDR_PC;
        ALUControl    = ALU_PASS;
        PCSrc         = PCSRC_ALU;
        WriteDataCtrl = WD_ALUOUT;
        rst_out       = 1'b0;

        case (state_q)
            RST: begin
                rst_out       = 1'b1;
                RegWrite      = 1'b1;
                RegWriteMUX   = RW_SP;
                WriteDataCtrl = WD_SP;
                state_d       = FETCH;
            end
            FETCH: begin
                MuxAddr    = ADDR_PC;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_4;
                ALUControl = ALU_ADD;
                if (wait_done) state_d = IR_LOAD;
            end
            IR_LOAD: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                PCSrc      = PCSRC_ALU;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_4;
                ALUControl = ALU_ADD;
                state_d    = DECODE;
            end
            DECODE: begin
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_IMM_SH;
                ALUControl = ALU_ADD;
                ALUOut_w   = 1'b1;
                ABWrite    = 1'b1;
                case (OPCODE)
                    OP_RTYPE: state_d = (funct == FN_ADD || funct == FN_SUB || funct == FN_AND)
                                        ? R_EX : EXC_OPC;
                    OP_ADDI:  state_d = ADDI_EX;
                    OP_LW,
                    OP_SW:    state_d = MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:   state_d = BRANCH;
                    OP_J:     state_d = JUMP;
                    OP_SRST:  state_d = RST;
                    default:  state_d = EXC_OPC;
                endcase
            end
            R_EX: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_B;
                ALUOut_w = 1'b1;
                case (funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_PASS;
                endcase
                // AND cannot overflow, so O is only honoured for add/sub
                state_d = (O && (funct == FN_ADD || funct == FN_SUB)) ? EXC_OVF : R_WB;
            end
            R_WB: begin
                RegWrite      = 1'b1;
                RegWriteMUX   = RW_RD;
                WriteDataCtrl = WD_ALUOUT;
                state_d       = FETCH;
            end
            ADDI_EX: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                ALUOut_w   = 1'b1;
                state_d    = O ? EXC_OVF : ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite      = 1'b1;
                RegWriteMUX   = RW_RT;
                WriteDataCtrl = WD_ALUOUT;
                state_d       = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                ALUOut_w   = 1'b1;
                state_d    = (OPCODE == OP_LW) ? LW_WAIT : SW;
            end
            LW_WAIT: begin
                MuxAddr = ADDR_ALUOUT;
                if (wait_done) state_d = LW_MDR;
            end
            LW_MDR: begin
                MDRWrite = 1'b1;
                state_d  = LW_WB;
            end
            LW_WB: begin
                RegWrite      = 1'b1;
                RegWriteMUX   = RW_RT;
                WriteDataCtrl = WD_MDR;
                state_d       = FETCH;
            end
            SW: begin
                MuxAddr = ADDR_ALUOUT;
                MemWR   = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ALUControl = ALU_SUB;
                PCSrc      = PCSRC_ALUOUT;
                PCWrite    = (OPCODE == OP_BEQ) ? equal : !equal;
                state_d    = FETCH;
            end
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JUMP;
                state_d = FETCH;
            end
            EXC_OVF, EXC_OPC: begin
                // PC already points past the faulting instruction; PC-4 goes to EPC
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_4;
                ALUControl = ALU_SUB;
                EPCWrite   = 1'b1;
                state_d    = EXC_RD;
            end
            EXC_RD: begin
                MuxAddr = cause_ovf_q ? ADDR_OVF : ADDR_OPC;
                if (wait_done) state_d = EXC_JMP;
            end
            EXC_JMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_EXC;
                state_d = FETCH;
            end
            default: state_d = RST;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: one controller with MEM_WAIT=3 and one with MEM_WAIT=5, outputs checked per cycle.
module tb_multicycle_ctrl;

    logic       clk  = 1'b0;
    logic       rst3 = 1'b1;
    logic       rst5 = 1'b1;
    logic       O    = 1'b0;
    logic       LT   = 1'b0;
    logic       GT   = 1'b0;
    logic [5:0] OPCODE = 6'd0;
    logic [5:0] funct  = 6'd0;

    always #5 clk = ~clk;

    logic       a_PCWrite, a_MemWR, a_IRWrite, a_ABWrite, a_MDRWrite, a_ALUOut_w, a_RegWrite, a_EPCWrite;
    logic [1:0] a_ALUSrcA, a_ALUSrcB, a_RegWriteMUX;
    logic [2:0] a_MuxAddr, a_ALUControl, a_PCSrc;
    logic [3:0] a_WriteDataCtrl;
    logic       a_rst_out;

    logic       b_PCWrite, b_MemWR, b_IRWrite, b_ABWrite, b_MDRWrite, b_ALUOut_w, b_RegWrite, b_EPCWrite;
    logic [1:0] b_ALUSrcA, b_ALUSrcB, b_RegWriteMUX;
    logic [2:0] b_MuxAddr, b_ALUControl, b_PCSrc;
    logic [3:0] b_WriteDataCtrl;
    logic       b_rst_out;

    multicycle_ctrl #(.MEM_WAIT(3), .RESET_SP(227)) u_dut3 (
        .clk(clk), .reset(rst3), .O(O), .LT(LT), .GT(GT), .OPCODE(OPCODE), .funct(funct),
        .PCWrite(a_PCWrite), .MemWR(a_MemWR), .IRWrite(a_IRWrite), .ABWrite(a_ABWrite),
        .MDRWrite(a_MDRWrite), .ALUOut_w(a_ALUOut_w), .RegWrite(a_RegWrite), .EPCWrite(a_EPCWrite),
        .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .RegWriteMUX(a_RegWriteMUX), .MuxAddr(a_MuxAddr),
        .ALUControl(a_ALUControl), .PCSrc(a_PCSrc), .WriteDataCtrl(a_WriteDataCtrl), .rst_out(a_rst_out)
    );

    multicycle_ctrl #(.MEM_WAIT(5), .RESET_SP(227)) u_dut5 (
        .clk(clk), .reset(rst5), .O(O), .LT(LT), .GT(GT), .OPCODE(OPCODE), .funct(funct),
        .PCWrite(b_PCWrite), .MemWR(b_MemWR), .IRWrite(b_IRWrite), .ABWrite(b_ABWrite),
        .MDRWrite(b_MDRWrite), .ALUOut_w(b_ALUOut_w), .RegWrite(b_RegWrite), .EPCWrite(b_EPCWrite),
        .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .RegWriteMUX(b_RegWriteMUX), .MuxAddr(b_MuxAddr),
        .ALUControl(b_ALUControl), .PCSrc(b_PCSrc), .WriteDataCtrl(b_WriteDataCtrl), .rst_out(b_rst_out)
    );

    // {PCWrite,MemWR,IRWrite,ABWrite,MDRWrite,ALUOut_w,RegWrite,EPCWrite,
    //  ALUSrcA,ALUSrcB,RegWriteMUX,MuxAddr,ALUControl,PCSrc,WriteDataCtrl,rst_out}
    logic [27:0] out3, out5;
    assign out3 = {a_PCWrite, a_MemWR, a_IRWrite, a_ABWrite, a_MDRWrite, a_ALUOut_w, a_RegWrite, a_EPCWrite,
                   a_ALUSrcA, a_ALUSrcB, a_RegWriteMUX, a_MuxAddr, a_ALUControl, a_PCSrc,
                   a_WriteDataCtrl, a_rst_out};
    assign out5 = {b_PCWrite, b_MemWR, b_IRWrite, b_ABWrite, b_MDRWrite, b_ALUOut_w, b_RegWrite, b_EPCWrite,
                   b_ALUSrcA, b_ALUSrcB, b_RegWriteMUX, b_MuxAddr, b_ALUControl, b_PCSrc,
                   b_WriteDataCtrl, b_rst_out};

    int checks   = 0;
    int failures = 0;

    function automatic logic [27:0] mk(input logic [7:0] en, input logic [1:0] srca, input logic [1:0] srcb,
                                       input logic [1:0] rwm, input logic [2:0] maddr, input logic [2:0] aluc,
                                       input logic [2:0] pcsrc, input logic [3:0] wdc, input logic rsto);
        return {en, srca, srcb, rwm, maddr, aluc, pcsrc, wdc, rsto};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%07h exp=0x%07h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, then step past the next rising edge
    task automatic cyc(input string tag, input bit use5, input logic [27:0] e);
        @(negedge clk);
        check(tag, use5 ? {4'd0, out5} : {4'd0, out3}, {4'd0, e});
        @(posedge clk);
        #1;
    endtask

    // en bits:            PMIAMURE
    logic [27:0] E_RST, E_FETCH, E_IRL, E_DEC, E_RADD, E_RAND, E_RWB, E_ADDI_EX, E_EXC,
                 E_RD_OVF, E_RD_OPC, E_EJMP, E_BR_T, E_BR_N, E_JMP, E_MADDR, E_SW,
                 E_LWW, E_MDR, E_LWWB;

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic o,
                             input logic lt, input logic gt);
        OPCODE = op;
        funct  = fn;
        O      = o;
        LT     = lt;
        GT     = gt;
    endtask

    task automatic fetch_dec(input string tag, input bit use5, input int waits);
        for (int i = 0; i < waits; i++) cyc({tag, "_fetch"}, use5, E_FETCH);
        cyc({tag, "_irload"}, use5, E_IRL);
        cyc({tag, "_decode"}, use5, E_DEC);
    endtask

    initial begin
        E_RST     = mk(8'b00000010, 2'd0, 2'd0, 2'd3, 3'd0, 3'd0, 3'd0, 4'd10, 1'b1);
        E_FETCH   = mk(8'b00000000, 2'd0, 2'd1, 2'd0, 3'd0, 3'd1, 3'd0, 4'd0,  1'b0);
        E_IRL     = mk(8'b10100000, 2'd0, 2'd1, 2'd0, 3'd0, 3'd1, 3'd0, 4'd0,  1'b0);
        E_DEC     = mk(8'b00010100, 2'd0, 2'd3, 2'd0, 3'd0, 3'd1, 3'd0, 4'd0,  1'b0);
        E_RADD    = mk(8'b00000100, 2'd1, 2'd0, 2'd0, 3'd0, 3'd1, 3'd0, 4'd0,  1'b0);
        E_RAND    = mk(8'b00000100, 2'd1, 2'd0, 2'd0, 3'd0, 3'd3, 3'd0, 4'd0,  1'b0);
        E_RWB     = mk(8'b00000010, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0, 3'd0, 4'd0,  1'b0);
        E_ADDI_EX = mk(8'b00000100, 2'd1, 2'd2, 2'd0, 3'd0, 3'd1, 3'd0, 4'd0,  1'b0);
        E_EXC     = mk(8'b00000001, 2'd0, 2'd1, 2'd0, 3'd0, 3'd2, 3'd0, 4'd0,  1'b0);
        E_RD_OVF  = mk(8'b00000000, 2'd0, 2'd0, 2'd0, 3'd3, 3'd0, 3'd0, 4'd0,  1'b0);
        E_RD_OPC  = mk(8'b00000000, 2'd0, 2'd0, 2'd0, 3'd2, 3'd0, 3'd0, 4'd0,  1'b0);
        E_EJMP    = mk(8'b10000000, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd3, 4'd0,  1'b0);
        E_BR_T    = mk(8'b10000000, 2'd1, 2'd0, 2'd0, 3'd0, 3'd2, 3'd1, 4'd0,  1'b0);
        E_BR_N    = mk(8'b00000000, 2'd1, 2'd0, 2'd0, 3'd0, 3'd2, 3'd1, 4'd0,  1'b0);
        E_JMP     = mk(8'b10000000, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd2, 4'd0,  1'b0);
        E_MADDR   = mk(8'b00000100, 2'd1, 2'd2, 2'd0, 3'd0, 3'd1, 3'd0, 4'd0,  1'b0);
        E_SW      = mk(8'b01000000, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 4'd0,  1'b0);
        E_LWW     = mk(8'b00000000, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 4'd0,  1'b0);
        E_MDR     = mk(8'b00001000, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 4'd0,  1'b0);
        E_LWWB    = mk(8'b00000010, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 4'd1,  1'b0);

        #1;
        rst3 = 1'b0;
        rst5 = 1'b0;
        for (int i = 0; i < 3; i++) cyc("reset_hold", 1'b0, E_RST);
        rst3 = 1'b1;
        cyc("reset_release", 1'b0, E_RST);

        // ADD, no overflow
        set_instr(6'd0, 6'd32, 1'b0, 1'b0, 1'b0);
        fetch_dec("add", 1'b0, 3);
        cyc("add_rex", 1'b0, E_RADD);
        cyc("add_rwb", 1'b0, E_RWB);

        // AND ignores the overflow flag
        set_instr(6'd0, 6'd36, 1'b1, 1'b0, 1'b0);
        fetch_dec("and", 1'b0, 3);
        cyc("and_rex", 1'b0, E_RAND);
        cyc("and_rwb", 1'b0, E_RWB);

        // ADDI overflow: no register write, exception via vector 255
        set_instr(6'd8, 6'd0, 1'b1, 1'b0, 1'b0);
        fetch_dec("addi_ovf", 1'b0, 3);
        cyc("addi_ex", 1'b0, E_ADDI_EX);
        cyc("addi_epc", 1'b0, E_EXC);
        for (int i = 0; i < 3; i++) cyc("addi_exc_rd", 1'b0, E_RD_OVF);
        cyc("addi_exc_jmp", 1'b0, E_EJMP);

        set_instr(6'd4, 6'd0, 1'b0, 1'b0, 1'b0);
        fetch_dec("beq_eq", 1'b0, 3);
        cyc("beq_taken", 1'b0, E_BR_T);

        set_instr(6'd5, 6'd0, 1'b0, 1'b0, 1'b0);
        fetch_dec("bne_eq", 1'b0, 3);
        cyc("bne_not_taken", 1'b0, E_BR_N);

        set_instr(6'd4, 6'd0, 1'b0, 1'b1, 1'b0);
        fetch_dec("beq_lt", 1'b0, 3);
        cyc("beq_lt_not_taken", 1'b0, E_BR_N);

        set_instr(6'd5, 6'd0, 1'b0, 1'b0, 1'b1);
        fetch_dec("bne_gt", 1'b0, 3);
        cyc("bne_gt_taken", 1'b0, E_BR_T);

        set_instr(6'd2, 6'd0, 1'b0, 1'b0, 1'b0);
        fetch_dec("j", 1'b0, 3);
        cyc("j_jump", 1'b0, E_JMP);

        set_instr(6'd43, 6'd0, 1'b0, 1'b0, 1'b0);
        fetch_dec("sw", 1'b0, 3);
        cyc("sw_addr", 1'b0, E_MADDR);
        cyc("sw_write", 1'b0, E_SW);

        // Invalid opcode: exception via vector 254
        set_instr(6'd17, 6'd0, 1'b0, 1'b0, 1'b0);
        fetch_dec("opc17", 1'b0, 3);
        cyc("opc17_epc", 1'b0, E_EXC);
        for (int i = 0; i < 3; i++) cyc("opc17_exc_rd", 1'b0, E_RD_OPC);
        cyc("opc17_exc_jmp", 1'b0, E_EJMP);

        // R-type with unsupported funct is an invalid opcode too
        set_instr(6'd0, 6'd33, 1'b0, 1'b0, 1'b0);
        fetch_dec("badfn", 1'b0, 3);
        cyc("badfn_epc", 1'b0, E_EXC);
        cyc("badfn_exc_rd", 1'b0, E_RD_OPC);

        // Finish that exception, then software reset for one cycle
        cyc("badfn_exc_rd2", 1'b0, E_RD_OPC);
        cyc("badfn_exc_rd3", 1'b0, E_RD_OPC);
        cyc("badfn_exc_jmp", 1'b0, E_EJMP);
        set_instr(6'd63, 6'd0, 1'b0, 1'b0, 1'b0);
        fetch_dec("srst", 1'b0, 3);
        cyc("srst_rst", 1'b0, E_RST);

        set_instr(6'd35, 6'd0, 1'b0, 1'b0, 1'b0);
        fetch_dec("lw3", 1'b0, 3);
        cyc("lw3_addr", 1'b0, E_MADDR);
        for (int i = 0; i < 3; i++) cyc("lw3_wait", 1'b0, E_LWW);
        cyc("lw3_mdr", 1'b0, E_MDR);
        cyc("lw3_wb", 1'b0, E_LWWB);

        // Second LW, aborted by an asynchronous reset in LW_WAIT
        fetch_dec("lw3b", 1'b0, 3);
        cyc("lw3b_addr", 1'b0, E_MADDR);
        cyc("lw3b_wait", 1'b0, E_LWW);
        #2;
        rst3 = 1'b0;
        #1;
        check("async_reset_outputs", {4'd0, out3}, {4'd0, E_RST});
        check("async_reset_no_mdr", {31'd0, a_MDRWrite}, 32'd0);
        @(posedge clk);
        #1;
        check("async_reset_held", {4'd0, out3}, {4'd0, E_RST});

        // LW on the MEM_WAIT=5 instance
        rst5 = 1'b1;
        cyc("w5_reset_release", 1'b1, E_RST);
        fetch_dec("lw5", 1'b1, 5);
        cyc("lw5_addr", 1'b1, E_MADDR);
        for (int i = 0; i < 5; i++) cyc("lw5_wait", 1'b1, E_LWW);
        cyc("lw5_mdr", 1'b1, E_MDR);
        cyc("lw5_wb", 1'b1, E_LWWB);
        cyc("lw5_back_fetch", 1'b1, E_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
